pipe_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the 5-stage pipeline. It replaces the fixed forwarding/stall logic with one block that provides:
- EX operand forwarding selects.
- Load-use bubbles.
- Multi-cycle data-memory freeze (FSM plus counter).
- Taken-branch flush of FLUSH_DEPTH younger stages.
- Saturating stall/flush performance counters.
It sits beside the stage registers and drives their enable, flush and bubble controls.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrlState_e;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // The younger result in EX/MEM shadows an older one in MEM/WB.
    function automatic logic [1:0] fwdSelect(input logic memHit, input logic wbHit);
        if (memHit) begin
            return FWD_EXMEM;
        end
        if (wbHit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use
// bubbles, multi-cycle memory freeze, taken-branch flush and perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 3,
    parameter int FLUSH_DEPTH = 1,
    parameter int MEM_LAT     = 1,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_AW-1:0]      id_r1_addr,
    input  logic [REG_AW-1:0]      id_r2_addr,
    input  logic                   id_r1_used,
    input  logic                   id_r2_used,
    input  logic [REG_AW-1:0]      ex_r1_addr,
    input  logic [REG_AW-1:0]      ex_r2_addr,
    input  logic [REG_AW-1:0]      ex_dest,
    input  logic                   ex_reg_write,
    input  logic                   ex_is_load,
    input  logic [REG_AW-1:0]      mem_dest,
    input  logic                   mem_reg_write,
    input  logic                   mem_access,
    input  logic [REG_AW-1:0]      wb_dest,
    input  logic                   wb_reg_write,
    input  logic                   branch_taken,
    input  logic                   perf_clr,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   id_ex_bubble,
    output logic                   mem_wb_bubble,
    output logic [FLUSH_DEPTH-1:0] flush_mask,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic [CNT_W-1:0]       flush_events
);

    // A 1-bit counter is kept even when MEM_LAT is 1 or 2 so the width is never zero.
    localparam int WCNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LOAD = (MEM_LAT > 1) ? WCNT_W'(MEM_LAT - 2) : '0;
    localparam bit USE_FREEZE = (MEM_LAT > 1);

    ctrlState_e        state;
    ctrlState_e        stateNext;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcntNext;
    logic              freeze;
    logic              loadUse;
    logic              branchFlush;
    logic              inReset;
    logic              idSrc1Hit;
    logic              idSrc2Hit;

    assign inReset = !rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= stateNext;
            wcnt  <= wcntNext;
        end
    end

    // The access cycle itself freezes, then MEM_LAT-2 more; the release cycle ignores mem_access.
    always_comb begin
        stateNext = state;
        wcntNext  = wcnt;
        freeze    = 1'b0;
        case (state)
            RUN: begin
                if (mem_access && USE_FREEZE) begin
                    freeze    = 1'b1;
                    stateNext = MEM_WAIT;
                    wcntNext  = WCNT_LOAD;
                end
            end
            MEM_WAIT: begin
                if (wcnt != '0) begin
                    freeze   = 1'b1;
                    wcntNext = wcnt - WCNT_W'(1);
                end else begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    assign idSrc1Hit = id_r1_used && (id_r1_addr == ex_dest);
    assign idSrc2Hit = id_r2_used && (id_r2_addr == ex_dest);

    // Priority is freeze, then load-use, then branch; outputs sit at idle while in reset.
    always_comb begin
        loadUse       = 1'b0;
        branchFlush   = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!inReset) begin
            loadUse     = !freeze && ex_is_load && ex_reg_write && (idSrc1Hit || idSrc2Hit);
            branchFlush = branch_taken && !freeze && !loadUse;
            if (freeze) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (loadUse) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    assign flush_mask = {FLUSH_DEPTH{branchFlush}};

    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (!inReset) begin
            fwd_a_sel = fwdSelect(mem_reg_write && (mem_dest == ex_r1_addr),
                                  wb_reg_write && (wb_dest == ex_r1_addr));
            fwd_b_sel = fwdSelect(mem_reg_write && (mem_dest == ex_r2_addr),
                                  wb_reg_write && (wb_dest == ex_r2_addr));
        end
    end

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clk (clk),
        .rst (rst),
        .clr (perf_clr),
        .inc (freeze || loadUse),
        .q   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .clk (clk),
        .rst (rst),
        .clr (perf_clr),
        .inc (branchFlush),
        .q   (flush_events)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed steps then random traffic checked
// against a cycle-level model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW      = 3;
    localparam int FLUSH_DEPTH = 2;
    localparam int MEM_LAT     = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst;
    logic [REG_AW-1:0]      id_r1_addr, id_r2_addr;
    logic                   id_r1_used, id_r2_used;
    logic [REG_AW-1:0]      ex_r1_addr, ex_r2_addr, ex_dest;
    logic                   ex_reg_write, ex_is_load;
    logic [REG_AW-1:0]      mem_dest;
    logic                   mem_reg_write, mem_access;
    logic [REG_AW-1:0]      wb_dest;
    logic                   wb_reg_write;
    logic                   branch_taken;
    logic                   perf_clr;
    logic                   pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic                   id_ex_bubble, mem_wb_bubble;
    logic [FLUSH_DEPTH-1:0] flush_mask;
    logic [1:0]             fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0]       stall_cycles, flush_events;

    int total = 0;
    int bad   = 0;

    // Model state: cycles remaining in the current memory window, and counter values.
    int windowLeft = 0;
    int stallCnt   = 0;
    int flushCnt   = 0;

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .FLUSH_DEPTH(FLUSH_DEPTH), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .ex_r1_addr(ex_r1_addr), .ex_r2_addr(ex_r2_addr), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .mem_dest(mem_dest), .mem_reg_write(mem_reg_write), .mem_access(mem_access),
        .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .perf_clr(perf_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .flush_mask(flush_mask), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwdModel(input logic [REG_AW-1:0] src);
        if (mem_reg_write && mem_dest == src) return 2'd1;
        if (wb_reg_write && wb_dest == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic idleInputs();
        id_r1_addr = '0; id_r2_addr = '0; id_r1_used = 1'b0; id_r2_used = 1'b0;
        ex_r1_addr = '0; ex_r2_addr = '0; ex_dest = '0;
        ex_reg_write = 1'b0; ex_is_load = 1'b0;
        mem_dest = '0; mem_reg_write = 1'b0; mem_access = 1'b0;
        wb_dest = '0; wb_reg_write = 1'b0;
        branch_taken = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic applyStimulus();
        id_r1_addr    = 3'($urandom_range(0, 7));
        id_r2_addr    = 3'($urandom_range(0, 7));
        id_r1_used    = ($urandom_range(0, 1) == 1);
        id_r2_used    = ($urandom_range(0, 1) == 1);
        ex_r1_addr    = 3'($urandom_range(0, 7));
        ex_r2_addr    = 3'($urandom_range(0, 7));
        ex_dest       = 3'($urandom_range(0, 7));
        ex_reg_write  = ($urandom_range(0, 3) != 0);
        ex_is_load    = ($urandom_range(0, 2) == 0);
        mem_dest      = 3'($urandom_range(0, 7));
        mem_reg_write = ($urandom_range(0, 1) == 1);
        mem_access    = ($urandom_range(0, 5) == 0);
        wb_dest       = 3'($urandom_range(0, 7));
        wb_reg_write  = ($urandom_range(0, 1) == 1);
        branch_taken  = ($urandom_range(0, 3) == 0);
        perf_clr      = ($urandom_range(0, 29) == 0);
    endtask

    // Called just after a falling edge with inputs settled; checks, then advances the model over the next rising edge.
    task automatic checkOutput(input string tag);
        logic expFreeze, expLoadUse, expFlush;
        logic [1:0] expA, expB;
        #1;
        expFreeze = 1'b0; expLoadUse = 1'b0; expFlush = 1'b0; expA = 2'd0; expB = 2'd0;
        if (!rst) begin
            windowLeft = 0; stallCnt = 0; flushCnt = 0;
        end else begin
            expFreeze  = (windowLeft > 1) || (windowLeft == 0 && mem_access && MEM_LAT > 1);
            expLoadUse = !expFreeze && ex_is_load && ex_reg_write &&
                         ((id_r1_used && id_r1_addr == ex_dest) || (id_r2_used && id_r2_addr == ex_dest));
            expFlush   = branch_taken && !expFreeze && !expLoadUse;
            expA       = fwdModel(ex_r1_addr);
            expB       = fwdModel(ex_r2_addr);
        end
        chk({tag, "/pc_en"},         16'(pc_en),         16'(!(expFreeze || expLoadUse)));
        chk({tag, "/if_id_en"},      16'(if_id_en),      16'(!(expFreeze || expLoadUse)));
        chk({tag, "/id_ex_en"},      16'(id_ex_en),      16'(!expFreeze));
        chk({tag, "/ex_mem_en"},     16'(ex_mem_en),     16'(!expFreeze));
        chk({tag, "/id_ex_bubble"},  16'(id_ex_bubble),  16'(expLoadUse));
        chk({tag, "/mem_wb_bubble"}, 16'(mem_wb_bubble), 16'(expFreeze));
        chk({tag, "/flush_mask"},    16'(flush_mask),    expFlush ? 16'h3 : 16'h0);
        chk({tag, "/fwd_a_sel"},     16'(fwd_a_sel),     16'(expA));
        chk({tag, "/fwd_b_sel"},     16'(fwd_b_sel),     16'(expB));
        chk({tag, "/stall_cycles"},  16'(stall_cycles),  16'(stallCnt));
        chk({tag, "/flush_events"},  16'(flush_events),  16'(flushCnt));
        @(posedge clk);
        if (rst) begin
            if (windowLeft > 0) windowLeft--;
            else if (mem_access && MEM_LAT > 1) windowLeft = MEM_LAT - 1;
            if (perf_clr) begin
                stallCnt = 0;
                flushCnt = 0;
            end else begin
                if ((expFreeze || expLoadUse) && stallCnt < CNT_MAX) stallCnt++;
                if (expFlush && flushCnt < CNT_MAX) flushCnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic setLoadUse();
        ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_dest = 3'd2;
        id_r2_addr = 3'd2; id_r2_used = 1'b1;
    endtask

    initial begin
        idleInputs();
        rst = 1'b0;
        checkOutput("reset");
        rst = 1'b1;
        checkOutput("idle");

        mem_dest = 3'd3; mem_reg_write = 1'b1; wb_dest = 3'd3; wb_reg_write = 1'b1; ex_r1_addr = 3'd3;
        checkOutput("fwdExMem");
        chk("fwdExMemDirect", 16'(fwd_a_sel), 16'd1);
        mem_reg_write = 1'b0;
        checkOutput("fwdMemWb");
        chk("fwdMemWbDirect", 16'(fwd_a_sel), 16'd2);
        idleInputs();
        ex_r2_addr = 3'd0; mem_dest = 3'd0; mem_reg_write = 1'b1;
        checkOutput("fwdZeroReg");

        idleInputs();
        setLoadUse();
        checkOutput("loadUse");
        ex_is_load = 1'b0; ex_reg_write = 1'b0;
        checkOutput("afterBubble");
        chk("stallAfterLoadUse", 16'(stall_cycles), 16'd1);
        ex_is_load = 1'b1; ex_reg_write = 1'b1; id_r2_used = 1'b0;
        checkOutput("unusedSrc");

        idleInputs();
        mem_access = 1'b1;
        repeat (4) checkOutput("freeze");
        mem_access = 1'b0;
        repeat (2) checkOutput("release");
        chk("stallAfterFreeze", 16'(stall_cycles), 16'd4);

        idleInputs();
        branch_taken = 1'b1;
        checkOutput("branch");
        branch_taken = 1'b0;
        checkOutput("afterBranch");
        chk("flushEventsOne", 16'(flush_events), 16'd1);
        setLoadUse(); branch_taken = 1'b1;
        checkOutput("branchInStall");
        idleInputs(); mem_access = 1'b1; branch_taken = 1'b1;
        checkOutput("branchInFreeze");
        mem_access = 1'b0;
        repeat (3) checkOutput("branchHeldFreeze");

        idleInputs();
        perf_clr = 1'b1;
        checkOutput("clear");
        perf_clr = 1'b0;
        setLoadUse();
        repeat (20) checkOutput("satStall");
        chk("stallSaturated", 16'(stall_cycles), 16'd15);
        perf_clr = 1'b1;
        checkOutput("clearWithInc");
        idleInputs();
        checkOutput("cleared");

        mem_access = 1'b1;
        checkOutput("enterWait");
        mem_access = 1'b0;
        rst = 1'b0;
        checkOutput("midWaitReset");
        rst = 1'b1;
        checkOutput("afterReset");

        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            checkOutput("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
